// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with a one-byte valid/ready output buffer.
//               SIn is synchronised through two flops. Each frame bit is
//               sampled near the middle of its symbol by a free-running cycle
//               counter started at the detected start edge.
// Ports       : Clock        - system clock, rising edge
//               Reset        - asynchronous, active-low reset
//               SIn          - asynchronous serial input, idle high
//               DataOut      - received byte, meaningful while DataOutValid=1
//               DataOutValid - byte available in the output buffer
//               DataOutReady - consumer accepts the buffered byte
//               FramingError - one-cycle pulse, stop bit sampled low
//               Overrun      - one-cycle pulse, completed byte dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       FramingError,
    output logic       Overrun
);

    localparam int c_SYMBOL_EDGE_TIME = ClockFreq / BaudRate;
    localparam int c_SAMPLE_TIME      = c_SYMBOL_EDGE_TIME / 2;
    localparam int c_LAST_SAMPLE      = c_SAMPLE_TIME + 9 * c_SYMBOL_EDGE_TIME;
    localparam int c_CNT_W            = $clog2(c_LAST_SAMPLE + 1);

    localparam logic [c_CNT_W-1:0] c_SAMPLE_CNT = c_CNT_W'(c_SAMPLE_TIME);
    localparam logic [c_CNT_W-1:0] c_SYMBOL_CNT = c_CNT_W'(c_SYMBOL_EDGE_TIME);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_sinMeta;
    logic                 r_sinSync;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_nextSample;
    logic [2:0]           r_bitIdx;
    logic [7:0]           r_shift;
    logic [1:0]           r_settle;
    logic                 w_sample;

    // Sample point of the current frame bit. r_nextSample advances by one
    // symbol after every sample, so no multiplier is needed.
    assign w_sample = (r_count == r_nextSample);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sinMeta <= 1'b1;
            r_sinSync <= 1'b1;
        end else begin
            r_sinMeta <= SIn;
            r_sinSync <= r_sinMeta;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_nextSample <= c_SAMPLE_CNT;
            r_bitIdx     <= 3'd0;
            r_shift      <= 8'h00;
            r_settle     <= 2'd3;
            DataOut      <= 8'h00;
            DataOutValid <= 1'b0;
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            FramingError <= 1'b0;
            Overrun      <= 1'b0;

            // Consumer handshake; a byte loaded below in the same cycle wins.
            if (DataOutValid && DataOutReady) begin
                DataOutValid <= 1'b0;
            end

            // The synchroniser comes out of reset holding 1, which does not
            // reflect the real line. Hold in WAIT_IDLE until it has flushed so
            // a line that is still low mid-frame cannot be mistaken for idle.
            if (r_settle != 2'd0) begin
                r_settle <= r_settle - 2'd1;
                r_state  <= WAIT_IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!r_sinSync) begin
                            r_state      <= START;
                            r_count      <= '0;
                            r_nextSample <= c_SAMPLE_CNT;
                        end
                    end

                    START: begin
                        r_count <= r_count + c_CNT_ONE;
                        if (w_sample) begin
                            r_nextSample <= r_nextSample + c_SYMBOL_CNT;
                            if (r_sinSync) begin
                                r_state <= IDLE;      // glitch, not a start bit
                            end else begin
                                r_state  <= DATA;
                                r_bitIdx <= 3'd0;
                            end
                        end
                    end

                    DATA: begin
                        r_count <= r_count + c_CNT_ONE;
                        if (w_sample) begin
                            r_nextSample <= r_nextSample + c_SYMBOL_CNT;
                            // LSB arrives first, so shift in from the top.
                            r_shift <= {r_sinSync, r_shift[7:1]};
                            if (r_bitIdx == 3'd7) begin
                                r_state <= STOP;
                            end else begin
                                r_bitIdx <= r_bitIdx + 3'd1;
                            end
                        end
                    end

                    STOP: begin
                        r_count <= r_count + c_CNT_ONE;
                        if (w_sample) begin
                            if (r_sinSync) begin
                                if (!DataOutValid || DataOutReady) begin
                                    DataOut      <= r_shift;
                                    DataOutValid <= 1'b1;
                                end else begin
                                    Overrun <= 1'b1;
                                end
                                r_state <= IDLE;
                            end else begin
                                FramingError <= 1'b1;
                                r_state      <= WAIT_IDLE;
                            end
                        end
                    end

                    WAIT_IDLE: begin
                        if (r_sinSync) begin
                            r_state <= IDLE;
                        end
                    end

                    default: begin
                        r_state <= WAIT_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Scoreboard bench for uart_receiver. Stimulus pushes each byte
//               that must be delivered into a queue; a monitor pops and
//               compares on every valid/ready transfer and tallies pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_BIT = 434;

    logic       Clock;
    logic       Reset;
    logic       SIn;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;
    logic       FramingError;
    logic       Overrun;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cycle  = 0;

    logic [7:0] expQ[$];
    int unsigned validCycles = 0;
    int unsigned feCycles    = 0;
    int unsigned ovCycles    = 0;
    bit          latArmed    = 1'b0;
    int unsigned latCycle    = 0;
    logic        prevValid   = 1'b0;

    uart_receiver #(
        .ClockFreq(50_000_000),
        .BaudRate (115_200)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SIn         (SIn),
        .DataOut     (DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady),
        .FramingError(FramingError),
        .Overrun     (Overrun)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    always @(posedge Clock) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse bookkeeping and scoreboard compare on each transfer.
    always @(negedge Clock) begin
        if (Reset) begin
            if (DataOutValid) validCycles++;
            if (FramingError) feCycles++;
            if (Overrun)      ovCycles++;
            if (FramingError || Overrun)
                check("fe_ov_exclusive", {31'd0, FramingError & Overrun}, 32'd0);
            if (latArmed && DataOutValid && !prevValid) begin
                latCycle = cycle;
                latArmed = 1'b0;
            end
            if (DataOutValid && DataOutReady) begin
                if (expQ.size() == 0) begin
                    check("unexpected_byte", {24'd0, DataOut}, 32'hFFFF_FFFF);
                end else begin
                    check("transfer_data", {24'd0, DataOut}, {24'd0, expQ.pop_front()});
                end
            end
        end
        prevValid = DataOutValid;
    end

    task automatic sendBit(input logic v);
        SIn = v;
        repeat (c_BIT) @(posedge Clock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stopBit);
        SIn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        int unsigned v0, fe0, ov0, tFall, holdBad;
        logic [7:0] frame;

        Reset        = 1'b0;
        SIn          = 1'b1;
        DataOutReady = 1'b0;
        idle(3);
        check("reset_data",  {24'd0, DataOut}, 32'h00);
        check("reset_valid", {31'd0, DataOutValid}, 32'd0);
        check("reset_fe",    {31'd0, FramingError}, 32'd0);
        check("reset_ov",    {31'd0, Overrun}, 32'd0);
        Reset = 1'b1;
        idle(20);

        // 1: basic frame with Ready held high, latency and one-cycle Valid.
        DataOutReady = 1'b1;
        expQ.push_back(8'h7A);
        v0 = validCycles;
        tFall = cycle;
        latArmed = 1'b1;
        sendByte(8'h7A, 1'b1);
        idle(50);
        check("lat_seen", {31'd0, latArmed}, 32'd0);
        check("lat_ok", {31'd0, (latCycle - tFall >= 4125) && (latCycle - tFall <= 4127)}, 32'd1);
        check("valid_one_cycle", validCycles - v0, 32'd1);

        // 2: byte held while Ready low, released by a single Ready cycle.
        DataOutReady = 1'b0;
        expQ.push_back(8'hBB);
        sendByte(8'hBB, 1'b1);
        holdBad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (!DataOutValid || DataOut !== 8'hBB) holdBad++;
        end
        check("hold_bb_100", holdBad, 32'd0);
        @(posedge Clock); #1;
        DataOutReady = 1'b1;
        @(posedge Clock); #1;
        DataOutReady = 1'b0;
        check("valid_clear", {31'd0, DataOutValid}, 32'd0);

        // 3: back-to-back bytes with buffer full -> one overrun.
        fe0 = feCycles; ov0 = ovCycles;
        expQ.push_back(8'h12);
        sendByte(8'h12, 1'b1);
        sendByte(8'h21, 1'b1);
        idle(20);
        check("ovr_pulse", ovCycles - ov0, 32'd1);
        check("ovr_no_fe", feCycles - fe0, 32'd0);
        check("ovr_data_kept", {24'd0, DataOut}, 32'h12);
        check("ovr_valid", {31'd0, DataOutValid}, 32'd1);
        DataOutReady = 1'b1;
        idle(5);

        // 4: stop bit low -> framing error, then a clean frame.
        fe0 = feCycles; ov0 = ovCycles; v0 = validCycles;
        sendByte(8'h13, 1'b0);
        SIn = 1'b1;
        idle(30);
        check("fe_pulse", feCycles - fe0, 32'd1);
        check("fe_no_ov", ovCycles - ov0, 32'd0);
        check("fe_no_valid", validCycles - v0, 32'd0);
        expQ.push_back(8'h55);
        sendByte(8'h55, 1'b1);
        idle(30);

        // 5: short low glitch rejected as a false start.
        fe0 = feCycles; ov0 = ovCycles; v0 = validCycles;
        SIn = 1'b0;
        idle(100);
        SIn = 1'b1;
        idle(600);
        check("glitch_no_valid", validCycles - v0, 32'd0);
        check("glitch_no_pulse", (feCycles - fe0) + (ovCycles - ov0), 32'd0);
        expQ.push_back(8'hA5);
        sendByte(8'hA5, 1'b1);
        idle(30);

        // 6: reset during data bit 4 of 0x0F, released while line is low.
        fe0 = feCycles; ov0 = ovCycles; v0 = validCycles;
        frame = 8'h0F;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(frame[i]);
        SIn = frame[4];
        idle(200);
        Reset = 1'b0;
        #1;
        check("midreset_valid", {31'd0, DataOutValid}, 32'd0);
        idle(20);
        Reset = 1'b1;
        idle(c_BIT - 220 + 3 * c_BIT);
        sendBit(1'b1);
        idle(50);
        check("midreset_no_valid", validCycles - v0, 32'd0);
        check("midreset_no_pulse", (feCycles - fe0) + (ovCycles - ov0), 32'd0);
        expQ.push_back(8'h3C);
        sendByte(8'h3C, 1'b1);
        idle(50);

        check("queue_drained", expQ.size(), 32'd0);
        check("total_fe", feCycles, 32'd1);
        check("total_ov", ovCycles, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
